an_sec_decoder: RTL and testbench
=================================

Name: an_sec_decoder

Overview:
- Parametrised, sequential single-error-correcting decoder for AN (product) codes.
- Accepts a received codeword cw = A·D + e, where e ∈ {0, ±2^j}.
- Divides cw bit-serially to get quotient Q and syndrome s = cw mod A, then walks the powers-of-two residues 2^j mod A on the fly, with no LUT.
- Returns the corrected data D, the signed error location and a status code. Sits between the AN-coded datapath and the consumer, with valid/ready handshakes on both sides.

Parameters:
- A, 13837, odd code modulus.
- AW, 14, bit width of A and of every residue.
- NW, 38, codeword width.
- K, 24, data width; NW = K + AW.
- LW, 7, signed location width; must hold ±NW.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  codeword valid.
- in_ready  out  1  decoder idle, accepts codeword.
- in_cw  in  NW  received codeword, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  K  corrected data D, modulo 2^K.
- out_status  out  2  00 clean, 01 corrected, 10 uncorrectable, 11 unused.
- out_loc  out  LW  signed location: +(j+1) if +2^j was added, −(j+1) if −2^j, 0 if clean or uncorrectable.

Behaviour:
- Only clk is used. rst is sampled on the clk edge. It has priority over everything and aborts any operation in progress.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, out_status=00, out_loc=0, all internal registers 0.
- FSM states: IDLE, DIV, SEARCH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at edge T: latch in_cw, clear Q and s, set bit counter to NW−1, go to DIV.
- DIV (cycles T+1 .. T+NW), MSB first, one bit per cycle:
  - t = 2s + bit.
  - If t ≥ A: s = t − A and shift 1 into Q; else s = t and shift 0 into Q.
  - t needs AW+1 bits. Q is NW bits, internal.
  - After the LSB: if s = 0, go to DONE with status 00 and data = Q[K−1:0]; otherwise go to SEARCH with j=0, p=1, q=0.
- SEARCH, one index per cycle; index j is tested in cycle T+NW+1+j:
  - If s = p: status 01, loc = +(j+1), data = Q − q.
  - Else if s = A − p: status 01, loc = −(j+1), data = Q + q + 1.
  - Else if j = NW−1: status 10, loc 0, data = Q[K−1:0] unmodified.
  - Else advance: p' = 2p; if p' ≥ A then p' −= A and q' = 2q + 1, else q' = 2q; j += 1.
  - The +match is checked before the −match. Both cannot hold because A is odd.
  - Invariant: p = 2^j mod A and q = floor(2^j / A). q is NW bits wide.
  - Data arithmetic is done at NW width and truncated to K.
- Latency from accept edge T to the first out_valid cycle:
  - Clean: NW+1.
  - Corrected at index j: NW+2+j.
  - Uncorrectable: 2·NW+1.
- DONE:
  - out_valid=1 and outputs held stable until out_ready; in_ready=0.
  - On out_valid && out_ready: out_valid=0, then IDLE. A new codeword is accepted no earlier than the next cycle.
  - Outputs retain their last values after the handshake.
- in_valid outside IDLE is ignored; in_cw is not sampled.
- out_ready while out_valid=0 has no effect.
- Codewords ≥ 2^NW are not representable. A word that wrapped or carries a multi-bit error is reported with whatever status the search yields; detecting those is not required.

Decomposition:
- Shared package an_code_pkg:
  - constants A_24=13837, AW_24=14, NW_24=38, K_24=24;
  - status encodings ST_CLEAN, ST_CORR, ST_UNCORR;
  - FSM state enum.
- One sub-module, an_serial_divmod: bit-serial restoring divider (start, busy, done, Q, s), reused later by the encoder-check path.
- The residue walk (p, q) stays inline.

Test Plan:
- D=1000, cw=13837000, no error -> s=0, status 00, loc 0, data 1000; out_valid 39 cycles after accept.
- cw=13837001 -> status 01, loc +1, data 1000; latency 40.
- cw=13837000−16384=13820616 (Q=998, s=11290=A−2547) -> status 01, loc −15, data 1000; latency 54.
- cw = 1000·13837 + 2^37 -> status 01, loc +38, data 1000.
- cw = 13837000 + 3 -> status 10, loc 0, data = Q (1000); latency 77. Then hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
- Reset and handshake edges:
  - Assert rst mid-DIV -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0.
  - In a separate run: in_valid during SEARCH -> ignored.
  - Back-to-back codewords -> each result handshaked before the next accept.

Source files
------------

// File: rtl/an_code_pkg.sv
// Shared constants, status encodings and FSM state type for the AN(13837) code path.
package an_code_pkg;

  localparam int unsigned A_24  = 13837;
  localparam int unsigned AW_24 = 14;
  localparam int unsigned NW_24 = 38;
  localparam int unsigned K_24  = 24;

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_CORR   = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StSearch,
    StDone
  } dec_state_e;

endpackage

// File: rtl/an_serial_divmod.sv
// Bit-serial restoring divider by the constant A: one dividend bit per cycle, MSB first.
module an_serial_divmod #(
  parameter int unsigned A  = 13837,
  parameter int unsigned AW = 14,
  parameter int unsigned NW = 38
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [NW-1:0] dividend_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [NW-1:0] quot_o,
  output logic [AW-1:0] rem_o
);

  localparam int unsigned CW = $clog2(NW);
  localparam logic [CW-1:0] CntMax = CW'(NW - 1);
  localparam logic [AW:0] AExt = A[AW:0];

  logic [NW-1:0] dvd_q, quot_q;
  logic [AW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q;
  logic [AW:0]   t;
  logic          t_ge;

  always_comb begin
    t     = {rem_q, dvd_q[NW-1]};
    t_ge  = (t >= AExt);
    rem_d = t_ge ? AW'(t - AExt) : t[AW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dvd_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        dvd_q  <= dividend_i;
        quot_q <= '0;
        rem_q  <= '0;
        cnt_q  <= CntMax;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        dvd_q  <= {dvd_q[NW-2:0], 1'b0};
        quot_q <= {quot_q[NW-2:0], t_ge};
        rem_q  <= rem_d;
        cnt_q  <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/an_sec_decoder.sv
// Sequential single-error-correcting AN-code decoder: serial divide, then walk 2^j mod A.
module an_sec_decoder
  import an_code_pkg::*;
#(
  parameter int unsigned A  = A_24,
  parameter int unsigned AW = AW_24,
  parameter int unsigned NW = NW_24,
  parameter int unsigned K  = K_24,
  parameter int unsigned LW = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [NW-1:0] in_cw_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [K-1:0]  out_data_o,
  output logic [1:0]    out_status_o,
  output logic [LW-1:0] out_loc_o
);

  localparam int unsigned JW = $clog2(NW);
  localparam logic [JW-1:0] JMax = JW'(NW - 1);
  localparam logic [AW:0] AExt = A[AW:0];

  dec_state_e    state_q;
  logic          in_ready_q, out_valid_q;
  logic [K-1:0]  out_data_q;
  logic [1:0]    out_status_q;
  logic [LW-1:0] out_loc_q;
  logic [JW-1:0] j_q;
  logic [AW-1:0] p_q;
  logic [NW-1:0] q_q;

  logic          div_start, div_busy, div_done;
  logic [NW-1:0] quot;
  logic [AW-1:0] synd;

  assign div_start = (state_q == StIdle) && in_valid_i && !div_busy;

  an_serial_divmod #(
    .A  (A),
    .AW (AW),
    .NW (NW)
  ) u_divmod (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (div_start),
    .dividend_i (in_cw_i),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quot_o     (quot),
    .rem_o      (synd)
  );

  // Residue walk: p = 2^j mod A, q = floor(2^j / A), advanced by doubling.
  logic [AW:0]   p_dbl;
  logic          p_ge;
  logic [AW-1:0] p_nxt, neg_p;
  logic [NW-1:0] q_nxt;
  logic          match_pos, match_neg;
  logic [K-1:0]  data_pos, data_neg;
  logic [LW-1:0] loc_mag;

  always_comb begin
    p_dbl     = {p_q, 1'b0};
    p_ge      = (p_dbl >= AExt);
    p_nxt     = p_ge ? AW'(p_dbl - AExt) : p_dbl[AW-1:0];
    q_nxt     = {q_q[NW-2:0], p_ge};
    neg_p     = AW'(AExt - {1'b0, p_q});
    match_pos = (synd == p_q);
    match_neg = (synd == neg_p);
    data_pos  = K'(quot - q_q);
    data_neg  = K'(quot + q_q + NW'(1));
    loc_mag   = LW'(j_q) + LW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_status_q <= ST_CLEAN;
      out_loc_q    <= '0;
      j_q          <= '0;
      p_q          <= '0;
      q_q          <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (div_start) begin
            state_q    <= StDiv;
            in_ready_q <= 1'b0;
          end
        end
        StDiv: begin
          if (div_done) begin
            if (synd == '0) begin
              state_q      <= StDone;
              out_valid_q  <= 1'b1;
              out_status_q <= ST_CLEAN;
              out_loc_q    <= '0;
              out_data_q   <= quot[K-1:0];
            end else begin
              state_q <= StSearch;
              j_q     <= '0;
              p_q     <= AW'(1);
              q_q     <= '0;
            end
          end
        end
        StSearch: begin
          if (match_pos) begin
            state_q      <= StDone;
            out_valid_q  <= 1'b1;
            out_status_q <= ST_CORR;
            out_loc_q    <= loc_mag;
            out_data_q   <= data_pos;
          end else if (match_neg) begin
            state_q      <= StDone;
            out_valid_q  <= 1'b1;
            out_status_q <= ST_CORR;
            out_loc_q    <= -loc_mag;
            out_data_q   <= data_neg;
          end else if (j_q == JMax) begin
            state_q      <= StDone;
            out_valid_q  <= 1'b1;
            out_status_q <= ST_UNCORR;
            out_loc_q    <= '0;
            out_data_q   <= quot[K-1:0];
          end else begin
            j_q <= j_q + 1'b1;
            p_q <= p_nxt;
            q_q <= q_nxt;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_status_o = out_status_q;
  assign out_loc_o    = out_loc_q;

endmodule

// File: tb/tb_an_sec_decoder.sv
// Directed bench for an_sec_decoder: latency, correction, reset abort and handshake checks.
module tb_an_sec_decoder;

  localparam int unsigned NW = 38;
  localparam int unsigned K  = 24;
  localparam int unsigned LW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NW-1:0] in_cw = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [K-1:0]  out_data;
  logic [1:0]    out_status;
  logic [LW-1:0] out_loc;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  always #5 clk = ~clk;

  an_sec_decoder u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_cw_i      (in_cw),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_status_o (out_status),
    .out_loc_o    (out_loc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for in_ready, presents cw for one edge, then counts edges until out_valid.
  task automatic send(input logic [NW-1:0] cw, output int l);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    in_cw = cw;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 0;
    while (!out_valid && l < 200) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs_out_valid", {63'd0, out_valid}, 64'd0);
    chk("hs_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic check_result(input string tag, input int l, input int exp_l,
                              input logic [1:0] st, input logic [LW-1:0] loc);
    chk({tag, "_lat"}, 64'(l), 64'(exp_l));
    chk({tag, "_status"}, 64'(out_status), 64'(st));
    chk({tag, "_loc"}, 64'(out_loc), 64'(loc));
    chk({tag, "_data"}, 64'(out_data), 64'd1000);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_status", 64'(out_status), 64'd0);
    chk("rst_loc", 64'(out_loc), 64'd0);

    send(38'd13837000, lat);
    check_result("clean", lat, 39, 2'b00, 7'd0);
    handshake();
    chk("clean_retained", 64'(out_data), 64'd1000);

    // Back-to-back: accepted on the cycle right after the previous handshake.
    send(38'd13837001, lat);
    check_result("plus1", lat, 40, 2'b01, 7'd1);
    handshake();

    send(38'd13820616, lat);
    check_result("minus15", lat, 54, 2'b01, 7'h71);
    handshake();

    send(38'd137452790472, lat);
    check_result("plus38", lat, 77, 2'b01, 7'd38);
    handshake();

    send(38'd13837003, lat);
    check_result("uncorr", lat, 77, 2'b10, 7'd0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("hold_valid", {63'd0, out_valid}, 64'd1);
    chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    chk("hold_status", 64'(out_status), 64'd2);
    chk("hold_data", 64'(out_data), 64'd1000);
    handshake();

    // Abort mid-division: outputs currently hold the uncorrectable result.
    in_cw = 38'd13837001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_data", 64'(out_data), 64'd0);
    chk("abort_status", 64'(out_status), 64'd0);
    chk("abort_loc", 64'(out_loc), 64'd0);
    repeat (60) begin
      @(posedge clk); #1;
    end
    chk("abort_no_result", {63'd0, out_valid}, 64'd0);

    // in_valid asserted during SEARCH (edges 41..45 after accept) must be ignored.
    in_cw = 38'd13820616;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      in_valid = (lat >= 41 && lat < 46);
      in_cw = in_valid ? 38'd13837000 : 38'd13820616;
    end
    in_valid = 1'b0;
    check_result("search_ignore", lat, 54, 2'b01, 7'h71);
    handshake();

    send(38'd13837000, lat);
    check_result("after_ignore", lat, 39, 2'b00, 7'd0);
    handshake();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
